// File: rtl/input_debouncer_pkg.sv
// Shared constants for the input debouncer slice.
// Logic levels and the filter counter sizing helper.
package input_debouncer_pkg;

    localparam logic LOW  = 1'b0;
    localparam logic HIGH = 1'b1;

    // Bits needed to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/input_debouncer_if.sv
// Signal bundle between a bouncy source and its debouncer.
// The master drives raw; the slave returns the filtered level and diagnostics.
interface input_debouncer_if;

    logic raw;
    logic level;
    logic bouncing;
    logic glitch;

    modport master (
        output raw,
        input  level,
        input  bouncing,
        input  glitch
    );

    modport slave (
        input  raw,
        output level,
        output bouncing,
        output glitch
    );

endinterface

// File: rtl/input_debouncer_sync.sv
// Plain multi-flop synchroniser for one asynchronous level.
// No logic between stages so every flop can settle metastability.
module level_synchronizer
    import input_debouncer_pkg::*;
#(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = LOW
) (
    input  logic clk,
    input  logic reset_low,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    generate
        if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
            $error("level_synchronizer: STAGES must be 2..4");
        end
    endgenerate

    // Shift the raw input through the chain, stage 0 first.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            chain <= {STAGES{RESET_LEVEL}};
        end else begin
            chain <= {chain[STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchroniser plus counter-based stability filter for bouncy inputs.
// Reports candidate changes being timed and abandoned candidates.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_LEVEL   = LOW
) (
    input  logic clk,
    input  logic reset_low,
    input_debouncer_if.slave io
);

    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          synced;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          level_q;
    logic          level_next;
    logic          bouncing_q;
    logic          bouncing_next;
    logic          glitch_q;
    logic          glitch_next;
    logic          agree;
    logic          expire;
    logic          advance;

    generate
        if (STABLE_CYCLES < 1) begin : g_bad_stable
            $error("input_debouncer: STABLE_CYCLES must be >= 1");
        end
    endgenerate

    level_synchronizer #(
        .STAGES      (SYNC_STAGES),
        .RESET_LEVEL (RESET_LEVEL)
    ) u_sync (
        .clk       (clk),
        .reset_low (reset_low),
        .async_in  (io.raw),
        .sync_out  (synced)
    );

    assign agree   = (synced == level_q);
    assign expire  = !agree && (count == LAST);
    assign advance = !agree && (count != LAST);

    // Filter decision: reset on agreement, flip on terminal count, else time.
    always_comb begin
        count_next    = count;
        level_next    = level_q;
        bouncing_next = LOW;
        glitch_next   = LOW;
        unique case (1'b1)
            agree: begin
                count_next  = '0;
                glitch_next = (count != '0);
            end
            expire: begin
                level_next = synced;
                count_next = '0;
            end
            advance: begin
                count_next    = count + CW'(1);
                bouncing_next = HIGH;
            end
            default: begin
            end
        endcase
    end

    // Filter state and registered outputs.
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            count      <= '0;
            level_q    <= RESET_LEVEL;
            bouncing_q <= LOW;
            glitch_q   <= LOW;
        end else begin
            count      <= count_next;
            level_q    <= level_next;
            bouncing_q <= bouncing_next;
            glitch_q   <= glitch_next;
        end
    end

    assign io.level    = level_q;
    assign io.bouncing = bouncing_q;
    assign io.glitch   = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: three parameter sets driven by one raw input.
// A cycle model feeds a scoreboard; key latencies are also checked directly.
module tb_input_debouncer;
    import input_debouncer_pkg::*;

    logic clk;
    logic reset_low;
    logic raw;

    input_debouncer_if i0 ();
    input_debouncer_if i1 ();
    input_debouncer_if i2 ();

    assign i0.raw = raw;
    assign i1.raw = raw;
    assign i2.raw = raw;

    input_debouncer #(
        .SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_LEVEL(LOW)
    ) u0 (.clk(clk), .reset_low(reset_low), .io(i0.slave));

    input_debouncer #(
        .SYNC_STAGES(2), .STABLE_CYCLES(1), .RESET_LEVEL(LOW)
    ) u1 (.clk(clk), .reset_low(reset_low), .io(i1.slave));

    input_debouncer #(
        .SYNC_STAGES(2), .STABLE_CYCLES(4), .RESET_LEVEL(HIGH)
    ) u2 (.clk(clk), .reset_low(reset_low), .io(i2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nchk  = 0;

    int   sc [3] = '{4, 1, 4};
    logic rl [3] = '{LOW, LOW, HIGH};

    logic [1:0] m_sync [3];
    logic       m_lvl  [3];
    logic       m_bnc  [3];
    logic       m_gl   [3];
    int         m_cnt  [3];

    logic [8:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_sync[k] = {2{rl[k]}};
            m_lvl[k]  = rl[k];
            m_cnt[k]  = 0;
            m_bnc[k]  = LOW;
            m_gl[k]   = LOW;
        end
    endtask

    task automatic model_step(input logic r);
        logic s;
        for (int k = 0; k < 3; k++) begin
            s = m_sync[k][1];
            m_gl[k]  = LOW;
            m_bnc[k] = LOW;
            if (s == m_lvl[k]) begin
                m_gl[k]  = (m_cnt[k] != 0);
                m_cnt[k] = 0;
            end else if (m_cnt[k] == sc[k] - 1) begin
                m_lvl[k] = s;
                m_cnt[k] = 0;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
                m_bnc[k] = HIGH;
            end
            m_sync[k] = {m_sync[k][0], r};
        end
    endtask

    function automatic logic [8:0] model_vec();
        return {m_gl[2], m_bnc[2], m_lvl[2],
                m_gl[1], m_bnc[1], m_lvl[1],
                m_gl[0], m_bnc[0], m_lvl[0]};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {i2.glitch, i2.bouncing, i2.level,
                i1.glitch, i1.bouncing, i1.level,
                i0.glitch, i0.bouncing, i0.level};
    endfunction

    // Scoreboard consumer: compare each pending expectation mid-cycle.
    always @(negedge clk) begin : sb_check
        logic [8:0] e;
        logic [8:0] o;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            o = dut_vec();
            nchk++;
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("sb_u%0d_n%0d", k, nchk),
                    32'(o[3*k +: 3]), 32'(e[3*k +: 3]));
            end
        end
    end

    task automatic tick(input logic r);
        raw = r;
        @(posedge clk);
        model_step(r);
        sb.push_back(model_vec());
        #1;
    endtask

    initial begin
        raw       = LOW;
        reset_low = 1'b0;
        model_reset();
        #12;
        chk("rst_lvl0", 32'(i0.level), 32'(LOW));
        chk("rst_bnc0", 32'(i0.bouncing), 32'(LOW));
        chk("rst_gl0", 32'(i0.glitch), 32'(LOW));
        chk("rst_lvl2", 32'(i2.level), 32'(HIGH));

        @(negedge clk);
        reset_low = 1'b1;
        for (int t = 1; t <= 50; t++) begin
            tick(LOW);
            chk("idle_lvl0", 32'(i0.level), 32'(LOW));
            chk("idle_bnc0", 32'(i0.bouncing), 32'(LOW));
            chk("idle_gl0", 32'(i0.glitch), 32'(LOW));
            if (t == 5) chk("rh_lvl2_e5", 32'(i2.level), 32'(HIGH));
            if (t == 6) chk("rh_lvl2_e6", 32'(i2.level), 32'(LOW));
        end

        for (int t = 1; t <= 12; t++) begin
            tick(HIGH);
            chk($sformatf("step_lvl0_e%0d", t), 32'(i0.level),
                32'(t >= 6));
            if (t >= 3 && t <= 5)
                chk($sformatf("step_bnc0_e%0d", t), 32'(i0.bouncing),
                    32'(HIGH));
            if (t == 2) chk("sc1_lvl_e2", 32'(i1.level), 32'(LOW));
            if (t == 3) chk("sc1_lvl_e3", 32'(i1.level), 32'(HIGH));
            chk("sc1_bnc", 32'(i1.bouncing), 32'(LOW));
        end
        for (int t = 1; t <= 12; t++) begin
            tick(LOW);
            chk($sformatf("fall_lvl0_e%0d", t), 32'(i0.level),
                32'(t < 6));
        end

        tick(HIGH);
        tick(HIGH);
        for (int t = 3; t <= 12; t++) begin
            tick(LOW);
            chk("bnc_rej_lvl0", 32'(i0.level), 32'(LOW));
            chk($sformatf("bnc_rej_gl0_e%0d", t), 32'(i0.glitch),
                32'(t == 5));
            chk("sc1_gl", 32'(i1.glitch), 32'(LOW));
        end

        for (int i = 0; i < 10; i++) begin
            tick(logic'(i % 2 == 0));
            chk("press_tog_lvl0", 32'(i0.level), 32'(LOW));
        end
        for (int h = 1; h <= 12; h++) begin
            tick(HIGH);
            chk($sformatf("press_lvl0_h%0d", h), 32'(i0.level),
                32'(h >= 6));
        end
        for (int i = 0; i < 10; i++) begin
            tick(logic'(i % 2 == 1));
            chk("rel_tog_lvl0", 32'(i0.level), 32'(HIGH));
        end
        for (int h = 1; h <= 12; h++) begin
            tick(LOW);
            chk($sformatf("rel_lvl0_h%0d", h), 32'(i0.level),
                32'(h < 6));
        end

        for (int t = 1; t <= 4; t++) begin
            tick(HIGH);
        end
        chk("mid_bnc0_pre", 32'(i0.bouncing), 32'(HIGH));
        @(negedge clk);
        #1;
        reset_low = 1'b0;
        raw       = LOW;
        #1;
        model_reset();
        chk("mid_rst_lvl0", 32'(i0.level), 32'(LOW));
        chk("mid_rst_bnc0", 32'(i0.bouncing), 32'(LOW));
        chk("mid_rst_gl0", 32'(i0.glitch), 32'(LOW));
        chk("mid_rst_lvl1", 32'(i1.level), 32'(LOW));
        chk("mid_rst_lvl2", 32'(i2.level), 32'(HIGH));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_low = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick(LOW);
            chk("post_lvl0", 32'(i0.level), 32'(LOW));
            chk("post_gl0", 32'(i0.glitch), 32'(LOW));
        end

        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
